// File: rtl/slot_pkg.sv
// Shared types for the slot spin controller: FSM state encoding and reel values.
package slot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPIN,
    ST_WAIT,
    ST_EVAL,
    ST_PAYOUT
  } state_e;

  typedef logic [2:0] reel_t;

  localparam reel_t REEL_SEVEN = 3'd7;

endpackage

// File: rtl/slot_payout_eval.sv
// Combinational payout classifier: jackpot / triple / pair / nothing, times the bet,
// with the product formed four bits wider than the credit bus and then clamped.
module slot_payout_eval
  import slot_pkg::*;
#(
  parameter int CREDIT_W     = 8,
  parameter int JACKPOT_MULT = 10,
  parameter int TRIPLE_MULT  = 5,
  parameter int PAIR_MULT    = 2
) (
  input  reel_t               reel1,
  input  reel_t               reel2,
  input  reel_t               reel3,
  input  logic [1:0]          bet,
  output logic [CREDIT_W-1:0] payout,
  output logic                win,
  output logic                jackpot
);

  localparam int PW = CREDIT_W + 4;
  localparam logic [PW-1:0] MAX_CREDIT = {4'b0000, {CREDIT_W{1'b1}}};

  logic          triple;
  logic          pair;
  logic [PW-1:0] mult;
  logic [PW-1:0] prod;

  always_comb begin
    triple  = (reel1 == reel2) && (reel2 == reel3);
    pair    = !triple && ((reel1 == reel2) || (reel2 == reel3) || (reel1 == reel3));
    jackpot = triple && (reel1 == REEL_SEVEN);
    mult    = '0;
    if (jackpot)     mult = PW'(JACKPOT_MULT);
    else if (triple) mult = PW'(TRIPLE_MULT);
    else if (pair)   mult = PW'(PAIR_MULT);
    prod = mult * {{(PW-2){1'b0}}, bet};
    if (prod > MAX_CREDIT) payout = {CREDIT_W{1'b1}};
    else                   payout = prod[CREDIT_W-1:0];
    win = (payout != '0);
  end

endmodule

// File: rtl/slot_spin_ctrl.sv
// Slot machine spin sequencer: debit, strobe the reel generator, evaluate, pay out.
// Optional spin/win statistics counters are built when SLOT_STATS_EN is defined.
module slot_spin_ctrl
  import slot_pkg::*;
#(
  parameter int CREDIT_W     = 8,
  parameter int INIT_CREDITS = 10,
  parameter int JACKPOT_MULT = 10,
  parameter int TRIPLE_MULT  = 5,
  parameter int PAIR_MULT    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_in,
  input  logic                spin_req,
  input  logic [1:0]          bet,
  input  reel_t               rng1,
  input  reel_t               rng2,
  input  reel_t               rng3,
  output logic                rng_press,
  output reel_t               reel1,
  output reel_t               reel2,
  output reel_t               reel3,
  output logic [CREDIT_W-1:0] credits,
  output logic [CREDIT_W-1:0] payout,
  output logic                win,
  output logic                jackpot,
  output logic                busy,
  output logic                done
`ifdef SLOT_STATS_EN
  ,
  output logic [15:0]         spin_count,
  output logic [15:0]         win_count
`endif
);

  localparam int SW = CREDIT_W + 2;
  localparam logic [SW-1:0] MAX_CREDIT = {2'b00, {CREDIT_W{1'b1}}};

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic [1:0]          bet_q, bet_d;
  reel_t               reel1_q, reel1_d, reel2_q, reel2_d, reel3_q, reel3_d;
  logic [CREDIT_W-1:0] payout_q, payout_d;
  logic                win_q, win_d, jackpot_q, jackpot_d;
  logic                rng_press_q, rng_press_d;
  logic                busy_q, busy_d, done_q, done_d;

  logic [1:0]          eff_bet;
  logic [CREDIT_W-1:0] eval_payout;
  logic                eval_win, eval_jackpot;
  logic [CREDIT_W-1:0] add_amt;
  logic [1:0]          sub_amt;
  logic [SW-1:0]       credit_sum;

  slot_payout_eval #(
    .CREDIT_W     (CREDIT_W),
    .JACKPOT_MULT (JACKPOT_MULT),
    .TRIPLE_MULT  (TRIPLE_MULT),
    .PAIR_MULT    (PAIR_MULT)
  ) u_eval (
    .reel1   (rng1),
    .reel2   (rng2),
    .reel3   (rng3),
    .bet     (bet_q),
    .payout  (eval_payout),
    .win     (eval_win),
    .jackpot (eval_jackpot)
  );

  always_comb begin
    eff_bet     = (bet == 2'd0) ? 2'd1 : bet;
    state_d     = state_q;
    bet_d       = bet_q;
    reel1_d     = reel1_q;
    reel2_d     = reel2_q;
    reel3_d     = reel3_q;
    payout_d    = payout_q;
    win_d       = win_q;
    jackpot_d   = jackpot_q;
    add_amt     = '0;
    sub_amt     = '0;

    case (state_q)
      ST_IDLE: begin
        if (spin_req && (credits_q >= CREDIT_W'(eff_bet))) begin
          state_d   = ST_SPIN;
          sub_amt   = eff_bet;
          bet_d     = eff_bet;
          payout_d  = '0;
          win_d     = 1'b0;
          jackpot_d = 1'b0;
        end
      end
      ST_SPIN: state_d = ST_WAIT;
      // WAIT covers the generator's register stage; its outputs are settled by EVAL.
      ST_WAIT: state_d = ST_EVAL;
      ST_EVAL: begin
        state_d   = ST_PAYOUT;
        reel1_d   = rng1;
        reel2_d   = rng2;
        reel3_d   = rng3;
        payout_d  = eval_payout;
        win_d     = eval_win;
        jackpot_d = eval_jackpot;
      end
      ST_PAYOUT: begin
        state_d = ST_IDLE;
        add_amt = payout_q;
      end
      default: state_d = ST_IDLE;
    endcase

    // Debit never exceeds the balance, so the only clamp needed is at the top.
    credit_sum = {2'b00, credits_q} + {{(SW-1){1'b0}}, coin_in}
               + {2'b00, add_amt} - {{(SW-2){1'b0}}, sub_amt};
    credits_d  = (credit_sum > MAX_CREDIT) ? {CREDIT_W{1'b1}} : credit_sum[CREDIT_W-1:0];

    rng_press_d = (state_d == ST_SPIN);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_PAYOUT);
  end

`ifdef SLOT_STATS_EN
  logic [15:0] spin_count_q, spin_count_d;
  logic [15:0] win_count_q, win_count_d;

  always_comb begin
    spin_count_d = spin_count_q;
    win_count_d  = win_count_q;
    if (state_q == ST_IDLE && state_d == ST_SPIN) spin_count_d = spin_count_q + 16'd1;
    if (state_q == ST_PAYOUT && win_q)            win_count_d  = win_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spin_count_q <= '0;
      win_count_q  <= '0;
    end else begin
      spin_count_q <= spin_count_d;
      win_count_q  <= win_count_d;
    end
  end

  assign spin_count = spin_count_q;
  assign win_count  = win_count_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      credits_q   <= CREDIT_W'(INIT_CREDITS);
      bet_q       <= '0;
      reel1_q     <= '0;
      reel2_q     <= '0;
      reel3_q     <= '0;
      payout_q    <= '0;
      win_q       <= 1'b0;
      jackpot_q   <= 1'b0;
      rng_press_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      credits_q   <= credits_d;
      bet_q       <= bet_d;
      reel1_q     <= reel1_d;
      reel2_q     <= reel2_d;
      reel3_q     <= reel3_d;
      payout_q    <= payout_d;
      win_q       <= win_d;
      jackpot_q   <= jackpot_d;
      rng_press_q <= rng_press_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rng_press = rng_press_q;
  assign reel1     = reel1_q;
  assign reel2     = reel2_q;
  assign reel3     = reel3_q;
  assign credits   = credits_q;
  assign payout    = payout_q;
  assign win       = win_q;
  assign jackpot   = jackpot_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/slot_spin_ctrl.md
SLOT_SPIN_CTRL -- requirements
Module: slot_spin_ctrl

Interface
REQ-001 Parameter CREDIT_W, 8, width of the credit balance and payout buses.
REQ-002 Parameter INIT_CREDITS, 10, credit balance loaded at reset.
REQ-003 Parameter JACKPOT_MULT, 10, payout multiplier for reels 7-7-7.
REQ-004 Parameter TRIPLE_MULT, 5, payout multiplier for any other three-of-a-kind.
REQ-005 Parameter PAIR_MULT, 2, payout multiplier for exactly two equal reels.
REQ-006 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1, asynchronous, active-low; asserts immediately and is released synchronously to clk by the integrator.
REQ-008 Port coin_in, input, 1, one-cycle pulse that adds one credit.
REQ-009 Port spin_req, input, 1, level request to start a spin; sampled only in IDLE.
REQ-010 Port bet, input, 2, credits wagered (1-3); value 0 is treated as 1.
REQ-011 Port rng1 / rng2 / rng3, input, 3 each, reel values from the upstream random generator.
REQ-012 Port rng_press, output, 1, one-cycle advance strobe to the upstream generator (its button_press).
REQ-013 Port reel1 / reel2 / reel3, output, 3 each, latched reel values of the last evaluated spin.
REQ-014 Port credits, output, CREDIT_W, current balance.
REQ-015 Port payout, output, CREDIT_W, amount awarded by the last spin.
REQ-016 Port win / jackpot, output, 1 each, levels describing the last spin, valid from EVAL until the next spin starts.
REQ-017 Port busy, output, 1, high in every state except IDLE.
REQ-018 Port done, output, 1, one-cycle pulse in the PAYOUT cycle.

Function
REQ-019 The FSM SHALL have the states IDLE, SPIN, WAIT, EVAL and PAYOUT, with the transitions IDLE->SPIN->WAIT->EVAL->PAYOUT->IDLE, one cycle each except IDLE.
REQ-020 IDLE SHALL go to SPIN only when spin_req=1 and credits >= effective bet; otherwise it SHALL stay in IDLE with no debit.
REQ-021 On the IDLE->SPIN edge the block SHALL deduct the effective bet from credits and clear win, jackpot and payout.
REQ-022 rng_press SHALL be 1 for exactly the SPIN cycle, and 0 in every other state.
REQ-023 WAIT SHALL absorb the one-cycle upstream register latency; EVAL SHALL latch rng1..3 into reel1..3.
REQ-024 In EVAL the payout SHALL be JACKPOT_MULT*bet for 7-7-7, TRIPLE_MULT*bet for another triple, PAIR_MULT*bet for exactly one pair, and 0 otherwise; win = payout!=0 and jackpot = 7-7-7.
REQ-025 In PAYOUT the block SHALL add the payout to credits, saturating at 2^CREDIT_W-1.
REQ-026 coin_in SHALL be honoured in every state, saturating at the maximum.
REQ-027 When coin_in coincides with a debit or payout, the net result SHALL be applied in one cycle, with saturation after the sum.
REQ-028 The payout product SHALL be computed at CREDIT_W+4 bits and then saturated to CREDIT_W.
REQ-029 spin_req asserted outside IDLE SHALL be ignored; if it is still held high in IDLE, a new spin SHALL start (auto-repeat).

Reset
REQ-030 While reset=0, the block SHALL be in state IDLE with credits=INIT_CREDITS, all other outputs 0 and rng_press=0.
REQ-031 A reset asserted mid-spin SHALL abort the spin without any refund of the debited bet; the balance SHALL return to INIT_CREDITS.

Configuration
REQ-032 With SLOT_STATS_EN defined, the block SHALL add 16-bit outputs spin_count and win_count, which increment on SPIN and on a PAYOUT with win=1 respectively, wrap at 16'hFFFF to 0, and reset to 0.
REQ-033 Without SLOT_STATS_EN, those ports and their counters SHALL not exist.

Structure
REQ-034 Package slot_pkg SHALL hold the FSM state enum, the 3-bit reel type, and the REEL_SEVEN=3'd7 constant.
REQ-035 Payout classification SHALL live in a combinational sub-module, slot_payout_eval (three reels and bet in; payout, win and jackpot out).

Verification
REQ-036 Reset, spin_req=1, bet=1, rng=3/3/3 -> rng_press high 1 cycle; in EVAL reels=3/3/3; payout=5; credits 10->9->14; done pulse.
REQ-037 bet=3, rng=7/7/7 -> jackpot=1, payout=30, credits 10->7->37.
REQ-038 bet=0, rng=2/5/2 -> effective bet 1, payout=2, credits 10->9->11; rng=1/2/4 -> payout=0, win=0.
REQ-039 Drain credits to 1 with bet=1 losses, then bet=2 -> no spin; busy stays 0; credits remain 1.
REQ-040 credits=254, coin_in plus PAYOUT of 5 in the same cycle -> credits=255 (saturated).
REQ-041 Reset pulsed during WAIT -> IDLE; credits=10; rng_press=0; no done pulse.
